// File: rtl/visaccum.sv
// visaccum: sink for the correlator visibility daisy-chain.
// Accumulates BLOCKS frames of narrow partial visibilities into one of two
// banks, then streams the completed bank out over a valid/ready interface
// while the other bank keeps accumulating.
// Optional feature macro: VISACCUM_SATURATE_EN (clamp instead of wrap on add).
module visaccum #(
    parameter int unsigned ABITS  = 4,
    parameter int unsigned VBITS  = 24,
    parameter int unsigned NVIS   = 120,
    parameter int unsigned BLOCKS = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid_i,
    input  logic                 frame_i,
    input  logic [ABITS-1:0]     revis_i,
    input  logic [ABITS-1:0]     imvis_i,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic [2*VBITS-1:0]   m_tdata,
    output logic                 overflow_o,
    output logic                 framing_o
);

    localparam int unsigned DW = 2 * VBITS;
    localparam int unsigned IW = $clog2(NVIS);
    localparam int unsigned BW = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(NVIS - 1);
    localparam logic [BW-1:0] LastBlk = BW'(BLOCKS - 1);

    // Parameter sanity checks at elaboration.
`ifdef VISACCUM_SATURATE_EN
    if (VBITS < ABITS) begin : g_width_check
        $error("visaccum: VBITS must be >= ABITS");
    end
`else
    if (VBITS < ABITS + $clog2(BLOCKS)) begin : g_width_check
        $error("visaccum: VBITS must be >= ABITS + clog2(BLOCKS)");
    end
`endif
    if (NVIS < 2) begin : g_nvis_check
        $error("visaccum: NVIS must be >= 2");
    end
    if (BLOCKS < 1) begin : g_blocks_check
        $error("visaccum: BLOCKS must be >= 1");
    end

    typedef enum logic [1:0] {StIdle, StFetch, StShow} rd_state_e;

    // Two banks of {re, im} sums; bank wbank_q accumulates, the other drains.
    logic [DW-1:0]    mem_q [2][NVIS];

    logic             wbank_q;
    logic [IW-1:0]    widx_q;
    logic [BW-1:0]    blk_q;
    logic             overflow_q;
    logic             framing_q;

    // Second pipeline stage of the read-modify-write.
    logic             s1_valid_q;
    logic             s1_bank_q;
    logic             s1_clear_q;
    logic [IW-1:0]    s1_idx_q;
    logic [ABITS-1:0] s1_re_q;
    logic [ABITS-1:0] s1_im_q;
    logic [DW-1:0]    s1_old_q;

    rd_state_e        rd_state_q;
    logic [IW-1:0]    ridx_q;
    logic [IW-1:0]    ridx_nxt;
    logic             tvalid_q;
    logic             tlast_q;
    logic [DW-1:0]    tdata_q;

    logic             is_last;
    logic             frame_err;
    logic             period_end;
    logic             rd_idle;
    logic             swap;
    logic [VBITS-1:0] new_re;
    logic [VBITS-1:0] new_im;

    // Frame position decode and swap decision for the word on the input.
    always_comb begin
        is_last    = (widx_q == LastIdx);
        frame_err  = valid_i && (frame_i != is_last);
        period_end = valid_i && frame_i && is_last && (blk_q == LastBlk);
        // A final handshake in this cycle frees the readout bank in time.
        rd_idle    = (rd_state_q == StIdle) ||
                     ((rd_state_q == StShow) && m_tready && (ridx_q == LastIdx));
        swap       = period_end && rd_idle;
        ridx_nxt   = ridx_q + 1'b1;
    end

    // Input-side control: indices, block count, bank select, sticky flags, read issue.
    always_ff @(posedge clock) begin
        if (reset) begin
            wbank_q    <= 1'b0;
            widx_q     <= '0;
            blk_q      <= '0;
            overflow_q <= 1'b0;
            framing_q  <= 1'b0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= valid_i;
            if (valid_i) begin
                s1_bank_q  <= wbank_q;
                s1_idx_q   <= widx_q;
                s1_clear_q <= (blk_q == '0);
                s1_re_q    <= revis_i;
                s1_im_q    <= imvis_i;
                s1_old_q   <= mem_q[wbank_q][widx_q];
                if (frame_err) begin
                    // Partial period is abandoned; the word itself still lands.
                    framing_q <= 1'b1;
                    widx_q    <= '0;
                    blk_q     <= '0;
                end else if (frame_i) begin
                    widx_q <= '0;
                    if (blk_q == LastBlk) begin
                        blk_q <= '0;
                        if (rd_idle) begin
                            wbank_q <= ~wbank_q;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end else begin
                        blk_q <= blk_q + 1'b1;
                    end
                end else begin
                    widx_q <= widx_q + 1'b1;
                end
            end
        end
    end

    // Add stage: first block of a period overwrites, later blocks accumulate.
`ifdef VISACCUM_SATURATE_EN
    logic [VBITS:0] re_sum;
    logic [VBITS:0] im_sum;
    always_comb begin
        re_sum = {1'b0, s1_old_q[DW-1:VBITS]} + (VBITS + 1)'(s1_re_q);
        im_sum = {1'b0, s1_old_q[VBITS-1:0]} + (VBITS + 1)'(s1_im_q);
        if (s1_clear_q) begin
            new_re = VBITS'(s1_re_q);
            new_im = VBITS'(s1_im_q);
        end else begin
            new_re = re_sum[VBITS] ? '1 : re_sum[VBITS-1:0];
            new_im = im_sum[VBITS] ? '1 : im_sum[VBITS-1:0];
        end
    end
`else
    logic [VBITS-1:0] re_sum;
    logic [VBITS-1:0] im_sum;
    always_comb begin
        re_sum = s1_old_q[DW-1:VBITS] + VBITS'(s1_re_q);
        im_sum = s1_old_q[VBITS-1:0] + VBITS'(s1_im_q);
        if (s1_clear_q) begin
            new_re = VBITS'(s1_re_q);
            new_im = VBITS'(s1_im_q);
        end else begin
            new_re = re_sum;
            new_im = im_sum;
        end
    end
`endif

    // Bank write-back; contents need no reset since each period starts by overwriting.
    always_ff @(posedge clock) begin
        if (s1_valid_q) begin
            mem_q[s1_bank_q][s1_idx_q] <= {new_re, new_im};
        end
    end

    // Readout FSM with registered stream outputs; prefetches on handshake for full rate.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state_q <= StIdle;
            ridx_q     <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
        end else begin
            unique case (rd_state_q)
                StIdle: begin
                    if (swap) begin
                        rd_state_q <= StFetch;
                        ridx_q     <= '0;
                    end
                end
                StFetch: begin
                    tdata_q    <= mem_q[~wbank_q][ridx_q];
                    tlast_q    <= (ridx_q == LastIdx);
                    tvalid_q   <= 1'b1;
                    rd_state_q <= StShow;
                end
                StShow: begin
                    if (m_tready) begin
                        if (ridx_q == LastIdx) begin
                            tvalid_q   <= 1'b0;
                            tlast_q    <= 1'b0;
                            ridx_q     <= '0;
                            rd_state_q <= swap ? StFetch : StIdle;
                        end else begin
                            ridx_q  <= ridx_nxt;
                            tdata_q <= mem_q[~wbank_q][ridx_nxt];
                            tlast_q <= (ridx_nxt == LastIdx);
                        end
                    end
                end
                default: begin
                    rd_state_q <= StIdle;
                    tvalid_q   <= 1'b0;
                end
            endcase
        end
    end

    assign m_tvalid   = tvalid_q;
    assign m_tlast    = tlast_q;
    assign m_tdata    = tdata_q;
    assign overflow_o = overflow_q;
    assign framing_o  = framing_q;

endmodule

// File: doc/visaccum.md
# visaccum

Receiver/sink for the correlator visibility daisy-chain. It takes the `valid`/`frame`/`revis`/`imvis` stream from the last correlator stage and adds each narrow partial visibility into a wide per-visibility accumulator. After `BLOCKS` frames it hands the completed sums to a ping-pong buffer and streams them out over a valid/ready interface. It sits between the correlator chain and the readout/DMA logic.

## Interface

Parameters:
- `ABITS`, 4: input partial-sum width, unsigned.
- `VBITS`, 24: accumulator and output component width; must be ≥ `ABITS`+clog2(`BLOCKS`).
- `NVIS`, 120: visibility words per frame; must be ≥ 2.
- `BLOCKS`, 16: frames accumulated per output period; must be ≥ 1.

Ports:
- `clock` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `valid_i` in 1: input word present this cycle.
- `frame_i` in 1: qualifies with `valid_i`; marks the last word of a frame.
- `revis_i` in `ABITS`: real partial sum.
- `imvis_i` in `ABITS`: imaginary partial sum.
- `m_tvalid` out 1: output word valid.
- `m_tready` in 1: downstream accept.
- `m_tlast` out 1: last word of a period (index `NVIS`-1).
- `m_tdata` out 2·`VBITS`: {re, im}, re in the upper half.
- `overflow_o` out 1: sticky; a completed period was dropped.
- `framing_o` out 1: sticky; `frame_i` did not coincide with index `NVIS`-1.

## Operation

- Storage: two banks (0 and 1), each `NVIS` × 2·`VBITS`. `wbank` selects the accumulating bank; the other bank is the readout bank.
- Write index `widx` runs 0..`NVIS`-1, advances on each `valid_i`, and wraps to 0 after the word with `frame_i`. Block counter `blk` runs 0..`BLOCKS`-1.
- Accumulate rule:
  - When `blk`==0, the stored value is `revis_i`/`imvis_i` zero-extended to `VBITS`. This overwrites the old contents, so no clear pass is needed.
  - Otherwise the stored value is the old value plus the zero-extended input, modulo 2^`VBITS`.
- Read-modify-write is pipelined:
  - Read is issued in the input cycle; add and write happen the next cycle.
  - Consecutive words always target distinct addresses, so there is no hazard.
  - No backpressure on the input: a word is accepted every cycle `valid_i` is high.
- Framing check:
  - `frame_i` with `widx`≠`NVIS`-1: the word is still accumulated, `framing_o` is set, `widx` goes to 0, and `blk` restarts at 0 (partial period discarded).
  - `widx`==`NVIS`-1 without `frame_i`: same handling.
- Swap: on the accepted word with `frame_i`, `widx`==`NVIS`-1 and `blk`==`BLOCKS`-1:
  - Readout idle: toggle `wbank`, set `blk` to 0, start readout of the completed bank.
  - Readout busy: do not toggle, set `blk` to 0 (the period is overwritten), set `overflow_o`. The readout in progress continues unaffected.
- Readout FSM:
  - IDLE → on swap → FETCH.
  - FETCH: read index `ridx` (starting at 0); registers the word → SHOW.
  - SHOW: hold `m_tvalid`=1 with stable `m_tdata`/`m_tlast` until `m_tready`.
  - On handshake: if `ridx`==`NVIS`-1 → IDLE; else increment `ridx` and prefetch, so SHOW persists with no bubble under continuous `m_tready`.
- The readout bank is never written while readout is active.

## Timing

- Reset values:
  - `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `overflow_o`=0, `framing_o`=0.
  - `wbank`=0, `widx`=0, `blk`=0, FSM=IDLE.
  - Bank contents are undefined; the first period overwrites them.
- Reset mid-readout abandons the stream immediately: `m_tvalid`=0 on the next cycle and no partial `m_tlast`.
- Latency: with the swap word accepted in cycle t, `m_tvalid` rises in cycle t+2 with index 0.
- Throughput: one output word per cycle while `m_tready`=1. A period drains in `NVIS` cycles minimum.
- `m_tdata` and `m_tlast` must not change while `m_tvalid`&&!`m_tready`.
- A swap in the same cycle as the final readout handshake counts as readout idle: there is no overflow and the new readout starts at t+2.
- Sticky flags are cleared only by reset.

## Configuration

- `VISACCUM_SATURATE_EN` defined: the accumulate add clamps each component at 2^`VBITS`-1, and `VBITS` ≥ `ABITS` is the only width constraint.
- Undefined: the add wraps modulo 2^`VBITS`, and the parameter constraint above is enforced by an elaboration-time check.

## Test plan

Unless stated otherwise: `NVIS`=4, `BLOCKS`=2, `ABITS`=4, `VBITS`=8.

- Two frames of re={1,2,3,4} and im={5,6,7,8}, with `m_tready`=1 → 4 words re={2,4,6,8}, im={10,12,14,16}; `m_tlast` on word 3; first `m_tvalid` 2 cycles after the final input word.
- Second period of all-ones following the first, with `m_tready` held 0 for 10 cycles during the first readout → first readout words hold stable values. Second period completes while readout is busy → `overflow_o`=1 and the second period is absent from the output.
- `frame_i` asserted on index 2 → `framing_o`=1. The next 2 full frames of value 3 yield 4 words of re=im=6.
- `m_tready` toggling 1,0,1,0 → each word is delivered exactly once, in index order 0..3.
- Reset asserted during SHOW at index 1 → `m_tvalid`=0 the next cycle, and all flags, indices and bank select return to reset values.
- `VISACCUM_SATURATE_EN` with `VBITS`=4 and `BLOCKS`=2, input value 15 twice → output 15, not 14.
